map_access_arbiter: RTL and testbench

//  Shares the single-port world-map BRAM (N*N entries, 8b cells, HIGH_PERFORMANCE, 2-cycle read)

---
 rtl/map_access_arbiter_pkg.sv | 31 +++
 rtl/map_access_arbiter_if.sv | 32 +++
 rtl/map_access_arbiter_tag_pipe.sv | 27 ++
 rtl/map_access_arbiter.sv | 77 +++++++
 tb/tb_map_access_arbiter.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/map_access_arbiter_pkg.sv
// Shared world-map access types: geometry constants, requester ids and the in-flight tag.
// Used by the arbiter, the raycaster and the player controller.
package map_pkg;

  localparam int N        = 24;
  localparam int COORD_W  = $clog2(N);
  localparam int ADDR_W   = $clog2(N * N);
  localparam int BRAM_LAT = 2;
  localparam int TAG_DEPTH = 1 + BRAM_LAT;
  localparam logic [7:0] OOB_CELL = 8'hFF;
  localparam logic [COORD_W-1:0] N_COORD = COORD_W'(N);

  typedef enum logic {REQ_RAY, REQ_CTL} req_id_t;

  typedef struct packed {
    logic    valid;
    req_id_t id;
    logic    oob;
  } map_tag_t;

  function automatic logic is_oob(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    return (x >= N_COORD) || (y >= N_COORD);
  endfunction

  // Row-major: y selects the row of N cells.
  function automatic logic [ADDR_W-1:0] cell_addr(input logic [COORD_W-1:0] x,
                                                  input logic [COORD_W-1:0] y);
    return ADDR_W'(y) * ADDR_W'(N) + ADDR_W'(x);
  endfunction

endpackage

// File: rtl/map_access_arbiter_if.sv
// Requester handshakes, shared response and BRAM port of the map access arbiter.
// slave is the arbiter side; master is the requester/BRAM side.
interface map_access_arbiter_if;
  import map_pkg::*;

  logic                ray_req;
  logic [COORD_W-1:0]  ray_x;
  logic [COORD_W-1:0]  ray_y;
  logic                ray_gnt;
  logic                ray_valid;

  logic                ctl_req;
  logic [COORD_W-1:0]  ctl_x;
  logic [COORD_W-1:0]  ctl_y;
  logic                ctl_gnt;
  logic                ctl_valid;

  logic [7:0]          rsp_data;
  logic [ADDR_W-1:0]   map_addr;
  logic [7:0]          map_data;

  modport slave (
    input  ray_req, ray_x, ray_y, ctl_req, ctl_x, ctl_y, map_data,
    output ray_gnt, ray_valid, ctl_gnt, ctl_valid, rsp_data, map_addr
  );

  modport master (
    output ray_req, ray_x, ray_y, ctl_req, ctl_x, ctl_y, map_data,
    input  ray_gnt, ray_valid, ctl_gnt, ctl_valid, rsp_data, map_addr
  );

endinterface

// File: rtl/map_access_arbiter_tag_pipe.sv
// Shift register carrying request tags alongside the address register and BRAM read stages.
// Synchronous clear drops every in-flight tag.
module map_tag_pipe
  import map_pkg::*;
#(
  parameter int DEPTH = TAG_DEPTH
) (
  input  logic     clk,
  input  logic     clr,
  input  map_tag_t din,
  output map_tag_t dout
);

  map_tag_t stages [DEPTH];

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < DEPTH; i++) stages[i] <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/map_access_arbiter.sv
// Round-robin sharing of the single-port map BRAM between the ray stepper and the controller,
// with fixed 3-cycle grant-to-response latency and out-of-bounds cells reported as walls.
//
// rr pointer (last_gnt) | meaning
// REQ_CTL               | ctl granted last (reset value): ray wins a tie
// REQ_RAY               | ray granted last: ctl wins a tie
module map_access_arbiter
  import map_pkg::*;
(
  input  logic                 pixel_clk_in,
  input  logic                 rst_in,
  map_access_arbiter_if.slave  bus
);

  req_id_t            last_gnt, last_gnt_nxt;
  logic               ray_gnt, ctl_gnt, issue;
  logic [COORD_W-1:0] sel_x, sel_y;
  logic [ADDR_W-1:0]  map_addr_q, map_addr_nxt;
  map_tag_t           issue_tag, rsp_tag;

  always_comb begin
    ray_gnt      = 1'b0;
    ctl_gnt      = 1'b0;
    sel_x        = bus.ray_x;
    sel_y        = bus.ray_y;
    issue_tag    = '0;
    last_gnt_nxt = last_gnt;
    map_addr_nxt = map_addr_q;
    // No grants while in reset so a requester never believes it was served and then lost.
    if (!rst_in) begin
      if (bus.ray_req && (!bus.ctl_req || last_gnt == REQ_CTL)) begin
        ray_gnt = 1'b1;
      end else if (bus.ctl_req) begin
        ctl_gnt = 1'b1;
      end
    end
    issue = ray_gnt || ctl_gnt;
    if (ctl_gnt) begin
      sel_x = bus.ctl_x;
      sel_y = bus.ctl_y;
    end
    if (issue) begin
      issue_tag.valid = 1'b1;
      issue_tag.id    = ctl_gnt ? REQ_CTL : REQ_RAY;
      issue_tag.oob   = is_oob(sel_x, sel_y);
      last_gnt_nxt    = issue_tag.id;
      map_addr_nxt    = issue_tag.oob ? '0 : cell_addr(sel_x, sel_y);
    end
  end

  always_ff @(posedge pixel_clk_in) begin
    if (rst_in) begin
      last_gnt   <= REQ_CTL;
      map_addr_q <= '0;
    end else begin
      last_gnt   <= last_gnt_nxt;
      map_addr_q <= map_addr_nxt;
    end
  end

  map_tag_pipe #(.DEPTH(TAG_DEPTH)) u_tag_pipe (
    .clk  (pixel_clk_in),
    .clr  (rst_in),
    .din  (issue_tag),
    .dout (rsp_tag)
  );

  assign bus.ray_gnt   = ray_gnt;
  assign bus.ctl_gnt   = ctl_gnt;
  assign bus.map_addr  = map_addr_q;
  assign bus.ray_valid = rsp_tag.valid && (rsp_tag.id == REQ_RAY);
  assign bus.ctl_valid = rsp_tag.valid && (rsp_tag.id == REQ_CTL);
  // Response data is forced to zero between responses to keep the shared bus quiet.
  assign bus.rsp_data  = !rsp_tag.valid ? 8'h00 :
                         rsp_tag.oob    ? OOB_CELL : bus.map_data;

endmodule

// File: tb/tb_map_access_arbiter.sv
// Directed plus randomized bench for map_access_arbiter against a queue-based reference model
// of grants, addresses and responses, with a behavioural 2-cycle BRAM.
module tb_map_access_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  map_access_arbiter_if bus ();

  map_access_arbiter dut (
    .pixel_clk_in (clk),
    .rst_in       (rst),
    .bus          (bus)
  );

  logic [7:0] mem [1024];
  logic [7:0] bram_r1;
  always @(posedge clk) begin
    bram_r1      <= mem[bus.map_addr];
    bus.map_data <= bram_r1;
  end

  typedef struct {
    int         due;
    bit         is_ctl;
    logic [7:0] data;
  } rsp_t;

  rsp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   ray_turn = 1'b1;
  int   exp_addr = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic step(input bit rr, input logic [4:0] rx, input logic [4:0] ry,
                      input bit cr, input logic [4:0] cx, input logic [4:0] cy,
                      input bit rs, output bit gr, output bit gc);
    bit         exp_rv, exp_cv, oob;
    logic [7:0] exp_d;
    int         x, y, a;
    rsp_t       e;
    @(posedge clk);
    cyc++;
    #1;
    chk("map_addr", 32'(bus.map_addr), exp_addr);
    rst         = rs;
    bus.ray_req = rr;
    bus.ray_x   = rx;
    bus.ray_y   = ry;
    bus.ctl_req = cr;
    bus.ctl_x   = cx;
    bus.ctl_y   = cy;
    #1;
    exp_rv = 1'b0;
    exp_cv = 1'b0;
    exp_d  = 8'h00;
    if (q.size() > 0 && q[0].due == cyc) begin
      e      = q.pop_front();
      exp_rv = !e.is_ctl;
      exp_cv = e.is_ctl;
      exp_d  = e.data;
    end
    chk("ray_valid", 32'(bus.ray_valid), 32'(exp_rv));
    chk("ctl_valid", 32'(bus.ctl_valid), 32'(exp_cv));
    if (exp_rv || exp_cv) chk("rsp_data", 32'(bus.rsp_data), 32'(exp_d));
    gr = !rs && rr && (!cr || ray_turn);
    gc = !rs && cr && !gr;
    chk("ray_gnt", 32'(bus.ray_gnt), 32'(gr));
    chk("ctl_gnt", 32'(bus.ctl_gnt), 32'(gc));
    if (gr || gc) begin
      x   = gc ? int'(cx) : int'(rx);
      y   = gc ? int'(cy) : int'(ry);
      oob = (x >= 24) || (y >= 24);
      a   = oob ? 0 : y * 24 + x;
      e.due    = cyc + 3;
      e.is_ctl = gc;
      e.data   = oob ? 8'hFF : mem[a];
      q.push_back(e);
      exp_addr = a;
      ray_turn = gc;
    end
    if (rs) begin
      q.delete();
      ray_turn = 1'b1;
      exp_addr = 0;
    end
  endtask

  task automatic idle(input int n);
    bit gr, gc;
    repeat (n) step(0, 0, 0, 0, 0, 0, 0, gr, gc);
  endtask

  task automatic serve(input bit re, input logic [4:0] rx, input logic [4:0] ry,
                       input bit ce, input logic [4:0] cx, input logic [4:0] cy);
    bit rp, cp, gr, gc;
    rp = re;
    cp = ce;
    for (int k = 0; k < 4 && (rp || cp); k++) begin
      step(rp, rx, ry, cp, cx, cy, 0, gr, gc);
      if (gr) rp = 0;
      if (gc) cp = 0;
    end
    chk("served", 32'({rp, cp}), 32'd0);
    idle(4);
  endtask

  function automatic logic [4:0] rand_coord();
    if ($urandom_range(0, 9) == 0) return 5'($urandom_range(24, 31));
    return 5'($urandom_range(0, 23));
  endfunction

  task automatic traffic(input int n, input bit saturate);
    bit rp, cp, gr, gc, rs;
    logic [4:0] rx, ry, cx, cy;
    rp = 0; cp = 0;
    rx = 0; ry = 0; cx = 0; cy = 0;
    for (int i = 0; i < n; i++) begin
      rs = !saturate && ($urandom_range(0, 999) == 0);
      if (!rp && (saturate || $urandom_range(0, 2) != 0)) begin
        rp = 1; rx = rand_coord(); ry = rand_coord();
      end
      if (!cp && (saturate || $urandom_range(0, 2) != 0)) begin
        cp = 1; cx = rand_coord(); cy = rand_coord();
      end
      if (!saturate && rp && $urandom_range(0, 63) == 0) rp = 0;
      if (!saturate && cp && $urandom_range(0, 63) == 0) cp = 0;
      step(rp, rx, ry, cp, cx, cy, rs, gr, gc);
      if (gr) rp = 0;
      if (gc) cp = 0;
    end
  endtask

  initial begin
    bit gr, gc;
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom_range(0, 254));
    bus.ray_req = 0; bus.ray_x = 0; bus.ray_y = 0;
    bus.ctl_req = 0; bus.ctl_x = 0; bus.ctl_y = 0;

    repeat (3) step(0, 0, 0, 0, 0, 0, 1, gr, gc);
    chk("rsp_data_reset", 32'(bus.rsp_data), 32'd0);

    // Single ray read at (3,2) -> address 51
    serve(1, 3, 2, 0, 0, 0);

    // Saturated contention straight after reset
    repeat (2) step(0, 0, 0, 0, 0, 0, 1, gr, gc);
    traffic(8, 1);
    idle(4);

    // Out-of-bounds controller read alongside ray traffic
    serve(1, 5, 5, 1, 24, 0);
    serve(0, 0, 0, 1, 24, 0);

    // Corner cells
    serve(1, 0, 0, 0, 0, 0);
    serve(0, 0, 0, 1, 23, 23);
    serve(1, 23, 0, 1, 0, 23);

    // Reset one cycle after a grant drops the response and restores ray-first
    step(1, 7, 7, 0, 0, 0, 0, gr, gc);
    step(0, 0, 0, 0, 0, 0, 1, gr, gc);
    idle(3);
    serve(1, 1, 1, 1, 2, 2);

    traffic(10000, 0);
    idle(6);
    chk("drained", 32'(q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
